// File: rtl/full_adder_pkg.sv
// Shared arithmetic helpers for the full adder cell and its bit-serial wrapper.
package full_adder_pkg;

    function automatic logic fa_sum(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

    function automatic logic fa_majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Purely combinational one-bit full adder: (a, b, cin) -> (s, co).
module full_adder_cell
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = fa_sum(a, b, cin);
    assign co = fa_majority(a, b, cin);

endmodule

// File: rtl/full_adder.sv
// Full adder cell with a registered LSB-first serial carry chain on the side.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out,
    input  logic clk,
    input  logic rst,
    input  logic ser_en,
    input  logic ser_first,
    output logic ser_sum,
    output logic ser_carry
);

    logic ser_sum_q, ser_sum_d;
    logic ser_carry_q, ser_carry_d;
    logic cin_eff;
    logic step_sum, step_carry;

    full_adder_cell u_comb_cell (
        .a   (a),
        .b   (b),
        .cin (c_in),
        .s   (sum),
        .co  (c_out)
    );

    // The first bit of a word seeds from c_in; later bits chain the stored carry.
    assign cin_eff = ser_first ? c_in : ser_carry_q;

    full_adder_cell u_serial_cell (
        .a   (a),
        .b   (b),
        .cin (cin_eff),
        .s   (step_sum),
        .co  (step_carry)
    );

    always_comb begin
        ser_sum_d   = ser_sum_q;
        ser_carry_d = ser_carry_q;
        if (ser_en) begin
            ser_sum_d   = step_sum;
            ser_carry_d = step_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ser_sum_q   <= 1'b0;
            ser_carry_q <= 1'b0;
        end else begin
            ser_sum_q   <= ser_sum_d;
            ser_carry_q <= ser_carry_d;
        end
    end

    assign ser_sum   = ser_sum_q;
    assign ser_carry = ser_carry_q;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: combinational truth table plus serial word adds.
module tb_full_adder;

    logic clk;
    logic rst;
    logic a, b, c_in;
    logic sum, c_out;
    logic ser_en, ser_first;
    logic ser_sum, ser_carry;

    int n_total;
    int n_bad;

    full_adder dut (
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sum       (sum),
        .c_out     (c_out),
        .clk       (clk),
        .rst       (rst),
        .ser_en    (ser_en),
        .ser_first (ser_first),
        .ser_sum   (ser_sum),
        .ser_carry (ser_carry)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    // Drive one serial-path cycle: inputs change at negedge, outputs sampled 1 unit after posedge.
    task automatic drive_cycle(input logic en, input logic first, input logic xa,
                               input logic xb, input logic xc, input logic xrst);
        @(negedge clk);
        ser_en    = en;
        ser_first = first;
        a         = xa;
        b         = xb;
        c_in      = xc;
        rst       = xrst;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            n_total++;
            if (ser_sum !== 1'b0 || ser_carry !== 1'b0) begin
                n_bad++;
                $display("FAIL reset[%0d]: got sum=%b carry=%b, need 0 0", i, ser_sum, ser_carry);
            end
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_comb_exhaustive();
        logic [7:0] exp_s;
        logic [7:0] exp_c;
        logic [2:0] v;
        exp_s = 8'b1001_0110;
        exp_c = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a, b, c_in} = v;
            #5;
            n_total++;
            if (sum !== exp_s[i] || c_out !== exp_c[i]) begin
                n_bad++;
                $display("FAIL comb_exhaustive[%0d]: got sum=%b c_out=%b, need %b %b",
                         i, sum, c_out, exp_s[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_comb_random();
        int total;
        for (int i = 0; i < 40; i++) begin
            a    = 1'($urandom_range(0, 1));
            b    = 1'($urandom_range(0, 1));
            c_in = 1'($urandom_range(0, 1));
            ser_en    = 1'($urandom_range(0, 1));
            ser_first = 1'($urandom_range(0, 1));
            #5;
            total = int'(a) + int'(b) + int'(c_in);
            n_total++;
            if (sum !== total[0] || c_out !== total[1]) begin
                n_bad++;
                $display("FAIL comb_random[%0d]: abc=%b%b%b got %b%b, need %b%b",
                         i, a, b, c_in, c_out, sum, total[1], total[0]);
            end
        end
        ser_en = 1'b0;
        ser_first = 1'b0;
    endtask

    task automatic test_serial_known();
        logic [3:0] xa;
        logic [3:0] xb;
        logic [3:0] exp_s;
        xa = 4'b1011;
        xb = 4'b0110;
        exp_s = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, (i == 0), xa[i], xb[i], 1'b0, 1'b0);
            n_total++;
            if (ser_sum !== exp_s[i]) begin
                n_bad++;
                $display("FAIL serial_known bit%0d: got %b, need %b", i, ser_sum, exp_s[i]);
            end
        end
        n_total++;
        if (ser_carry !== 1'b1) begin
            n_bad++;
            $display("FAIL serial_known carry: got %b, need 1", ser_carry);
        end
    endtask

    task automatic test_seed();
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        n_total++;
        if (ser_sum !== 1'b1 || ser_carry !== 1'b0) begin
            n_bad++;
            $display("FAIL seed: got sum=%b carry=%b, need 1 0", ser_sum, ser_carry);
        end
    endtask

    task automatic test_hold_mid_reset();
        // 1 + 1 with seed 1 -> sum 1, carry 1, then idle with ser_first wiggling.
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
            n_total++;
            if (ser_sum !== 1'b1 || ser_carry !== 1'b1) begin
                n_bad++;
                $display("FAIL hold[%0d]: got sum=%b carry=%b, need 1 1", i, ser_sum, ser_carry);
            end
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_total++;
        if (ser_sum !== 1'b0 || ser_carry !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: got sum=%b carry=%b, need 0 0", ser_sum, ser_carry);
        end
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        n_total++;
        if (ser_sum !== 1'b0 || ser_carry !== 1'b1) begin
            n_bad++;
            $display("FAIL after_reset: got sum=%b carry=%b, need 0 1", ser_sum, ser_carry);
        end
    endtask

    // Random words, back-to-back or with gaps, checked against integer addition.
    task automatic test_random_words();
        longint unsigned x, y, total, part, mask;
        int n, seed;
        logic exp_s, exp_c;
        for (int w = 0; w < 30; w++) begin
            n = int'($urandom_range(1, 16));
            x = longint'($urandom) & ((64'd1 << n) - 1);
            y = longint'($urandom) & ((64'd1 << n) - 1);
            seed = int'($urandom_range(0, 1));
            total = x + y + longint'(seed);
            for (int i = 0; i < n; i++) begin
                drive_cycle(1'b1, (i == 0), x[i], y[i], (i == 0) ? 1'(seed) : 1'($urandom_range(0, 1)), 1'b0);
                mask = (64'd1 << (i + 1)) - 1;
                part = (x & mask) + (y & mask) + longint'(seed);
                exp_s = total[i];
                exp_c = part[i + 1];
                n_total++;
                if (ser_sum !== exp_s || ser_carry !== exp_c) begin
                    n_bad++;
                    $display("FAIL word%0d bit%0d: got sum=%b carry=%b, need %b %b",
                             w, i, ser_sum, ser_carry, exp_s, exp_c);
                end
                if ($urandom_range(0, 5) == 0) begin
                    drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                    n_total++;
                    if (ser_sum !== exp_s || ser_carry !== exp_c) begin
                        n_bad++;
                        $display("FAIL word%0d idle: got sum=%b carry=%b, need %b %b",
                                 w, ser_sum, ser_carry, exp_s, exp_c);
                    end
                end
            end
            n_total++;
            if (ser_carry !== total[n]) begin
                n_bad++;
                $display("FAIL word%0d final_carry: got %b, need %b", w, ser_carry, total[n]);
            end
        end
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        c_in      = 1'b0;
        ser_en    = 1'b0;
        ser_first = 1'b0;
        test_comb_exhaustive();
        test_reset();
        test_serial_known();
        test_seed();
        test_hold_mid_reset();
        test_random_words();
        test_comb_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/full_adder.md
# full_adder

Single-bit full adder with a registered bit-serial carry chain, used as the basic arithmetic cell in ripple and serial adder datapaths. The primary outputs `sum`/`c_out` are a purely combinational function of `a`, `b`, `c_in`. A clocked side path reuses the same cell to add multi-bit operands one bit per cycle, LSB first, holding the carry in a flop.

## Interface
- Parameters: none.
- Port order is fixed. The first five positions are `a, b, c_in, sum, c_out` so that positional instantiation of the combinational cell works; the clocked ports follow.
- `clk`  input  1  single clock; all registers update on its rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `a`  input  1  addend bit.
- `b`  input  1  addend bit.
- `c_in`  input  1  carry in (combinational path); also the serial seed carry when `ser_first`=1.
- `sum`  output  1  combinational `a ^ b ^ c_in`.
- `c_out`  output  1  combinational majority(`a`, `b`, `c_in`).
- `ser_en`  input  1  advance the serial adder by one bit this cycle.
- `ser_first`  input  1  with `ser_en`, marks the LSB of a new operand pair; uses `c_in` instead of the stored carry.
- `ser_sum`  output  1  registered sum bit of the last serial step.
- `ser_carry`  output  1  registered carry of the last serial step, i.e. the carry into the next bit.

## Operation
- Combinational path:
  - `sum = a ^ b ^ c_in`.
  - `c_out = (a & b) | (a & c_in) | (b & c_in)`.
  - No dependency on `clk`, `rst` or any serial input.
  - Fully defined for all 8 input combinations.
- Serial path:
  - Effective carry: `cin_eff = ser_first ? c_in : ser_carry`.
  - When `ser_en`=1 on a rising edge: `ser_sum <= a ^ b ^ cin_eff` and `ser_carry <= majority(a, b, cin_eff)`.
  - When `ser_en`=0: both registers hold.
  - `ser_first` is ignored when `ser_en`=0.
  - Operand length is unbounded; the user counts bits.
  - After the MSB step, `ser_carry` is the final carry out.
- `rst`=1 on a rising edge clears `ser_sum` and `ser_carry` to 0 and overrides `ser_en`.
- Reset in the middle of a word discards the partial result. The next word must start with `ser_first`=1; otherwise it adds with a carry of 0.
- If `clk` and `rst` are left unconnected, the combinational outputs remain correct and the serial outputs are don't-care.

## Timing
- `sum`/`c_out`: zero-cycle latency, valid one propagation delay after any input change. Benches sample 5 time units after applying stimulus.
- `ser_sum`/`ser_carry`: one-cycle latency. The outputs reflect the inputs sampled at the previous rising edge where `ser_en`=1.
- Reset values: `ser_sum`=0, `ser_carry`=0. `sum`/`c_out` have no reset value because they are combinational.
- A new word may start on the cycle immediately after the MSB step (back-to-back words via `ser_first`).

## Structure
- No shared package content; no typedefs or constants are needed.
- One natural sub-module, `full_adder_cell`: purely combinational `(a, b, cin) -> (s, co)`.
  - Instantiated twice: once for the primary outputs, once with `cin_eff` for the serial path.
  - Alternatively, instantiate it once and mux only the register inputs.
- The top level contains the `cin_eff` mux and the two flops.

## Test plan
- Exhaustive combinational check: drive `{a,b,c_in}` = 0..7 with 5 time units between steps.
  - Required `sum`: 0,1,1,0,1,0,0,1.
  - Required `c_out`: 0,0,0,1,0,1,1,1.
- Reset: hold `rst`=1 for 2 cycles with `ser_en`=1 and `a`=`b`=1 -> `ser_sum`=0 and `ser_carry`=0 throughout.
- Serial add of 1011 + 0110 (11 + 6), LSB first, `c_in`=0, `ser_first` on bit 0 only:
  - `ser_sum` sequence 1,0,0,0.
  - Final `ser_carry`=1 (result 17).
- Seed carry: single step with `ser_first`=1, `a`=`b`=0, `c_in`=1 -> `ser_sum`=1, `ser_carry`=0.
- Hold and mid-word reset:
  - `ser_en`=0 for 3 cycles mid-word -> outputs unchanged.
  - Assert `rst` mid-word -> both outputs 0.
  - Next step without `ser_first`, `a`=1, `b`=1 -> `ser_sum`=0, `ser_carry`=1.
